// File: rtl/hp_lcd_pkg.sv
// ---------------------------------------------------------------------------
// hp_lcd_pkg
//   Shared definitions for the HP54542C LCD tap front end and the VGA
//   re-timer: lock-state encoding, default timing constants and a small
//   saturating-increment helper for the 10-bit position counters.
// ---------------------------------------------------------------------------
package hp_lcd_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } lock_state_e;

  // Default LCD timing, in LCD dot clocks / lines.
  localparam int DEF_CW            = 20;
  localparam int DEF_GAP_THRESH    = 1000;
  localparam int DEF_LINE_MIN      = 780;
  localparam int DEF_LINE_MAX      = 820;
  localparam int DEF_EXP_LINES     = 480;
  localparam int DEF_H_ACTIVE      = 640;
  localparam int DEF_LOCK_FRAMES   = 3;
  localparam int DEF_UNLOCK_FRAMES = 2;
  localparam int DEF_TIMEOUT       = 500000;

  // Increment that sticks at 1023 instead of wrapping.
  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/sync_interval_meter.sv
// ---------------------------------------------------------------------------
// sync_interval_meter
//   Detects rising edges of the LCD line sync, measures the number of clocks
//   between consecutive edges and flags a timeout when no edge arrives.
//   Ports:
//     iw_clk, reset  clock and synchronous active-high reset
//     iw_sync        raw LCD line sync
//     edge_valid     rising edge that has a previous edge as reference
//     interval       clocks since the previous edge (valid with edge_valid)
//     timeout        counter reached TIMEOUT without an edge this cycle
// ---------------------------------------------------------------------------
module sync_interval_meter
  import hp_lcd_pkg::*;
#(
  parameter int CW      = DEF_CW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          iw_clk,
  input  logic          reset,
  input  logic          iw_sync,
  output logic          edge_valid,
  output logic [CW-1:0] interval,
  output logic          timeout
);

  localparam logic [CW-1:0] CNT_MAX     = '1;
  localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

  logic          sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          have_ref_q, have_ref_d;
  logic          sync_edge;

  always_comb begin
    sync_edge  = iw_sync & ~sync_q;
    sync_d     = iw_sync;
    edge_valid = sync_edge & have_ref_q;
    interval   = cnt_q;
    // Passes TIMEOUT only once; afterwards the counter sits at CNT_MAX,
    // so the pulse cannot repeat during a long dropout.
    timeout    = ~sync_edge & (cnt_q == TIMEOUT_CNT);

    cnt_d      = cnt_q;
    have_ref_d = have_ref_q;
    if (sync_edge) begin
      // Loaded with 1 so the value seen at the next edge equals t1 - t0.
      cnt_d      = {{(CW-1){1'b0}}, 1'b1};
      have_ref_d = 1'b1;
    end else begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end
      if (timeout) begin
        have_ref_d = 1'b0;
      end
    end
  end

  always_ff @(posedge iw_clk) begin
    if (reset) begin
      // Sync starts "high" so a sync already high at release is no edge.
      sync_q     <= 1'b1;
      cnt_q      <= '0;
      have_ref_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      have_ref_q <= have_ref_d;
    end
  end

endmodule

// File: rtl/hp_lcd_frame_sync.sv
// ---------------------------------------------------------------------------
// hp_lcd_frame_sync
//   LCD-side timing recovery. Classifies sync edges as line or frame edges,
//   keeps hpos/vpos, checks line intervals and frame line counts and runs a
//   hysteretic lock FSM that gates the VGA re-timer.
//   Ports:
//     iw_clk, reset    LCD dot clock, synchronous active-high reset
//     iw_sync          LCD line sync
//     ow_line_start    1-clk strobe per accepted line or frame edge
//     ow_frame_start   1-clk strobe per frame edge
//     ow_hpos/ow_vpos  clocks since last edge / lines since frame edge
//     ow_active        locked and inside the active window
//     ow_locked        lock FSM in LOCKED
//     ow_line_period   last line-edge interval
//     ow_frame_lines   lines counted in the previous frame
//     ow_sync_err      pulse per illegal line interval or timeout
// ---------------------------------------------------------------------------
module hp_lcd_frame_sync
  import hp_lcd_pkg::*;
#(
  parameter int CW            = DEF_CW,
  parameter int GAP_THRESH    = DEF_GAP_THRESH,
  parameter int LINE_MIN      = DEF_LINE_MIN,
  parameter int LINE_MAX      = DEF_LINE_MAX,
  parameter int EXP_LINES     = DEF_EXP_LINES,
  parameter int H_ACTIVE      = DEF_H_ACTIVE,
  parameter int LOCK_FRAMES   = DEF_LOCK_FRAMES,
  parameter int UNLOCK_FRAMES = DEF_UNLOCK_FRAMES,
  parameter int TIMEOUT       = DEF_TIMEOUT
) (
  input  logic          iw_clk,
  input  logic          reset,
  input  logic          iw_sync,
  output logic          ow_line_start,
  output logic          ow_frame_start,
  output logic [9:0]    ow_hpos,
  output logic [9:0]    ow_vpos,
  output logic          ow_active,
  output logic          ow_locked,
  output logic [CW-1:0] ow_line_period,
  output logic [9:0]    ow_frame_lines,
  output logic          ow_sync_err
);

  logic          edge_valid;
  logic [CW-1:0] interval;
  logic          timeout;

  sync_interval_meter #(
    .CW      (CW),
    .TIMEOUT (TIMEOUT)
  ) u_meter (
    .iw_clk     (iw_clk),
    .reset      (reset),
    .iw_sync    (iw_sync),
    .edge_valid (edge_valid),
    .interval   (interval),
    .timeout    (timeout)
  );

  lock_state_e   state_q, state_d;
  logic [7:0]    good_cnt_q, good_cnt_d;
  logic [7:0]    bad_cnt_q, bad_cnt_d;
  logic          frame_bad_q, frame_bad_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          sync_err_q, sync_err_d;
  logic [9:0]    hpos_q, hpos_d;
  logic [9:0]    vpos_q, vpos_d;
  logic [CW-1:0] line_period_q, line_period_d;
  logic [9:0]    frame_lines_q, frame_lines_d;

  logic          frame_edge, line_edge, line_bad, frame_good;
  logic [9:0]    lines_seen;

  always_comb begin
    frame_edge = edge_valid && (interval > CW'(GAP_THRESH));
    line_edge  = edge_valid && !frame_edge;
    line_bad   = (interval < CW'(LINE_MIN)) || (interval > CW'(LINE_MAX));
    // The frame edge itself is the first line of the new frame, so the
    // closing frame held vpos+1 lines.
    lines_seen = sat_inc10(vpos_q);
    frame_good = (lines_seen == 10'(EXP_LINES)) && !frame_bad_q;

    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    sync_err_d    = 1'b0;
    hpos_d        = sat_inc10(hpos_q);
    vpos_d        = vpos_q;
    line_period_d = line_period_q;
    frame_lines_d = frame_lines_q;
    frame_bad_d   = frame_bad_q;
    state_d       = state_q;
    good_cnt_d    = good_cnt_q;
    bad_cnt_d     = bad_cnt_q;

    if (frame_edge) begin
      line_start_d  = 1'b1;
      frame_start_d = 1'b1;
      hpos_d        = '0;
      vpos_d        = '0;
      frame_lines_d = lines_seen;
      frame_bad_d   = 1'b0;
      case (state_q)
        ST_SEARCH: begin
          state_d    = ST_VERIFY;
          good_cnt_d = '0;
        end
        ST_VERIFY: begin
          if (frame_good) begin
            good_cnt_d = good_cnt_q + 8'd1;
            if (good_cnt_q + 8'd1 >= 8'(LOCK_FRAMES)) begin
              state_d   = ST_LOCKED;
              bad_cnt_d = '0;
            end
          end else begin
            good_cnt_d = '0;
          end
        end
        ST_LOCKED: begin
          if (frame_good) begin
            bad_cnt_d = '0;
          end else begin
            bad_cnt_d = bad_cnt_q + 8'd1;
            if (bad_cnt_q + 8'd1 >= 8'(UNLOCK_FRAMES)) begin
              state_d    = ST_SEARCH;
              bad_cnt_d  = '0;
              good_cnt_d = '0;
            end
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end else if (line_edge) begin
      line_start_d  = 1'b1;
      hpos_d        = '0;
      vpos_d        = sat_inc10(vpos_q);
      line_period_d = interval;
      // A malformed line still counts toward vpos; only the frame is marked.
      if (line_bad) begin
        sync_err_d  = 1'b1;
        frame_bad_d = 1'b1;
      end
    end else if (timeout) begin
      // The meter drops its reference, so the next edge only re-arms it.
      sync_err_d  = 1'b1;
      state_d     = ST_SEARCH;
      frame_bad_d = 1'b0;
      good_cnt_d  = '0;
      bad_cnt_d   = '0;
    end
  end

  always_ff @(posedge iw_clk) begin
    if (reset) begin
      state_q       <= ST_SEARCH;
      good_cnt_q    <= '0;
      bad_cnt_q     <= '0;
      frame_bad_q   <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
      hpos_q        <= '0;
      vpos_q        <= '0;
      line_period_q <= '0;
      frame_lines_q <= '0;
    end else begin
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
      bad_cnt_q     <= bad_cnt_d;
      frame_bad_q   <= frame_bad_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      sync_err_q    <= sync_err_d;
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      line_period_q <= line_period_d;
      frame_lines_q <= frame_lines_d;
    end
  end

  assign ow_line_start  = line_start_q;
  assign ow_frame_start = frame_start_q;
  assign ow_hpos        = hpos_q;
  assign ow_vpos        = vpos_q;
  assign ow_locked      = (state_q == ST_LOCKED);
  assign ow_active      = ow_locked && (hpos_q < 10'(H_ACTIVE)) && (vpos_q < 10'(EXP_LINES));
  assign ow_line_period = line_period_q;
  assign ow_frame_lines = frame_lines_q;
  assign ow_sync_err    = sync_err_q;

endmodule

// File: tb/tb_hp_lcd_frame_sync.sv
// ---------------------------------------------------------------------------
// tb_hp_lcd_frame_sync
//   Frame-level directed vectors on a scaled-down raster (4 lines of 30
//   clocks, 100-clock frame gap, 400-clock timeout). Each vector describes
//   one frame plus an optional lead-in (dropout or mid-frame reset) and the
//   values expected at its first sync edge.
// ---------------------------------------------------------------------------
module tb_hp_lcd_frame_sync;

  localparam int P_CW     = 16;
  localparam int P_GAP    = 60;
  localparam int P_LMIN   = 28;
  localparam int P_LMAX   = 32;
  localparam int P_EXP    = 4;
  localparam int P_HACT   = 20;
  localparam int P_LOCK   = 3;
  localparam int P_UNLOCK = 2;
  localparam int P_TO     = 400;

  localparam int PERIOD = 30;
  localparam int GAP    = 100;
  localparam int IDLE   = 350;

  localparam int PRE_NONE  = 0;
  localparam int PRE_IDLE  = 1;
  localparam int PRE_RESET = 2;
  localparam int NVEC      = 24;

  logic            clk = 1'b0;
  logic            reset;
  logic            sync;
  logic            ow_line_start, ow_frame_start, ow_active, ow_locked, ow_sync_err;
  logic [9:0]      ow_hpos, ow_vpos, ow_frame_lines;
  logic [P_CW-1:0] ow_line_period;

  hp_lcd_frame_sync #(
    .CW            (P_CW),
    .GAP_THRESH    (P_GAP),
    .LINE_MIN      (P_LMIN),
    .LINE_MAX      (P_LMAX),
    .EXP_LINES     (P_EXP),
    .H_ACTIVE      (P_HACT),
    .LOCK_FRAMES   (P_LOCK),
    .UNLOCK_FRAMES (P_UNLOCK),
    .TIMEOUT       (P_TO)
  ) dut (
    .iw_clk         (clk),
    .reset          (reset),
    .iw_sync        (sync),
    .ow_line_start  (ow_line_start),
    .ow_frame_start (ow_frame_start),
    .ow_hpos        (ow_hpos),
    .ow_vpos        (ow_vpos),
    .ow_active      (ow_active),
    .ow_locked      (ow_locked),
    .ow_line_period (ow_line_period),
    .ow_frame_lines (ow_frame_lines),
    .ow_sync_err    (ow_sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pre;
    int n_lines;
    int odd_idx;      // pulse whose incoming interval is odd_period (0 = none)
    int odd_period;
    bit chk_pos;      // check hpos ramp and ow_active on every cycle
    bit exp_fs;       // frame/line strobe at the first edge
    bit exp_locked;
    int exp_flines;
    int exp_errs;     // sync_err pulses from lead-in start to frame end
  } vec_t;

  vec_t vecs[NVEC];
  int   tests    = 0;
  int   failed   = 0;
  int   err_seen = 0;

  function automatic vec_t mk(int pre, int n, int oi, int op, bit cp,
                              bit fs, bit lk, int fl, int er);
    vec_t v;
    v.pre = pre; v.n_lines = n; v.odd_idx = oi; v.odd_period = op; v.chk_pos = cp;
    v.exp_fs = fs; v.exp_locked = lk; v.exp_flines = fl; v.exp_errs = er;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (ow_sync_err) err_seen++;
  endtask

  // One sync pulse; the next pulse may start intv clocks later.
  task automatic pulse(input int intv, input bit chk_pos, input bit exp_lk,
                       output bit s_ls, output bit s_fs, output bit s_lk,
                       output bit s_err, output int s_flines, output int s_period);
    int pos_bad;
    int exp_h;
    pos_bad = 0;
    s_ls = 1'b0; s_fs = 1'b0; s_lk = 1'b0; s_err = 1'b0; s_flines = 0; s_period = 0;
    sync = 1'b1;
    for (int k = 0; k < intv; k++) begin
      tick();
      if (k == 0) begin
        s_ls     = ow_line_start;
        s_fs     = ow_frame_start;
        s_lk     = ow_locked;
        s_err    = ow_sync_err;
        s_flines = int'(ow_frame_lines);
        s_period = int'(ow_line_period);
      end
      if (k == 3) sync = 1'b0;
      exp_h = (k > 1023) ? 1023 : k;
      if (chk_pos && ((int'(ow_hpos) != exp_h) || (ow_active != (exp_lk && (k < P_HACT)))))
        pos_bad++;
    end
    if (chk_pos) check("hpos_active_ramp_bad_cycles", pos_bad, 0);
  endtask

  task automatic run_frame(input int idx);
    vec_t v;
    int   err_base, intv, lines_ok, f_flines, t_flines, t_period;
    bit   f_ls, f_fs, f_lk, f_err, t_ls, t_fs, t_lk, t_err;
    v = vecs[idx];
    err_base = err_seen;
    lines_ok = 0;
    f_ls = 1'b0; f_fs = 1'b0; f_lk = 1'b0; f_err = 1'b0; f_flines = 0;

    if (v.pre == PRE_IDLE) begin
      repeat (IDLE) tick();
    end else if (v.pre == PRE_RESET) begin
      pulse(PERIOD, 1'b0, 1'b0, t_ls, t_fs, t_lk, t_err, t_flines, t_period);
      pulse(PERIOD, 1'b0, 1'b0, t_ls, t_fs, t_lk, t_err, t_flines, t_period);
      check($sformatf("v%0d_locked_before_reset", idx), ow_locked, 1);
      reset = 1'b1;
      tick();
      check($sformatf("v%0d_rst_line_start", idx), ow_line_start, 0);
      check($sformatf("v%0d_rst_frame_start", idx), ow_frame_start, 0);
      check($sformatf("v%0d_rst_hpos", idx), ow_hpos, 0);
      check($sformatf("v%0d_rst_vpos", idx), ow_vpos, 0);
      check($sformatf("v%0d_rst_locked", idx), ow_locked, 0);
      check($sformatf("v%0d_rst_active", idx), ow_active, 0);
      check($sformatf("v%0d_rst_line_period", idx), ow_line_period, 0);
      check($sformatf("v%0d_rst_frame_lines", idx), ow_frame_lines, 0);
      check($sformatf("v%0d_rst_sync_err", idx), ow_sync_err, 0);
      reset = 1'b0;
      tick();
      tick();
    end

    for (int i = 0; i < v.n_lines; i++) begin
      if (i == v.n_lines - 1)        intv = GAP;
      else if (i + 1 == v.odd_idx)   intv = v.odd_period;
      else                           intv = PERIOD;
      pulse(intv, v.chk_pos, v.exp_locked, t_ls, t_fs, t_lk, t_err, t_flines, t_period);
      if (i == 0) begin
        f_ls = t_ls; f_fs = t_fs; f_lk = t_lk; f_err = t_err; f_flines = t_flines;
      end else begin
        if (t_ls && !t_fs) lines_ok++;
        if (i == v.odd_idx) begin
          check($sformatf("v%0d_odd_line_period", idx), t_period, v.odd_period);
          check($sformatf("v%0d_odd_sync_err_pulse", idx), t_err, 1);
        end
      end
    end

    $display("[TB] vec %0d: pre=%0d lines=%0d fs=%0b ls=%0b locked=%0b flines=%0d errs=%0d period=%0d",
             idx, v.pre, v.n_lines, f_fs, f_ls, f_lk, f_flines, err_seen - err_base,
             int'(ow_line_period));
    check($sformatf("v%0d_frame_start", idx), f_fs, v.exp_fs);
    check($sformatf("v%0d_line_start_at_frame", idx), f_ls, v.exp_fs);
    check($sformatf("v%0d_locked", idx), f_lk, v.exp_locked);
    check($sformatf("v%0d_frame_lines", idx), f_flines, v.exp_flines);
    check($sformatf("v%0d_sync_err_count", idx), err_seen - err_base, v.exp_errs);
    check($sformatf("v%0d_line_strobes", idx), lines_ok, v.n_lines - 1);
    check($sformatf("v%0d_line_period_end", idx), ow_line_period, PERIOD);
  endtask

  initial begin
    int strobes;
    reset = 1'b1;
    sync  = 1'b1;

    //              pre        n  oi op  chk fs lk flines errs
    vecs[0]  = mk(PRE_NONE,  4, 0, 0,  0,  0, 0, 0, 0); // reference edge only
    vecs[1]  = mk(PRE_NONE,  4, 0, 0,  1,  1, 0, 4, 0); // SEARCH -> VERIFY
    vecs[2]  = mk(PRE_NONE,  4, 0, 0,  0,  1, 0, 4, 0);
    vecs[3]  = mk(PRE_NONE,  4, 0, 0,  0,  1, 0, 4, 0);
    vecs[4]  = mk(PRE_NONE,  4, 0, 0,  1,  1, 1, 4, 0); // locks at 4th frame_start
    vecs[5]  = mk(PRE_NONE,  3, 0, 0,  0,  1, 1, 4, 0);
    vecs[6]  = mk(PRE_NONE,  3, 0, 0,  0,  1, 1, 3, 0); // one short frame: hold
    vecs[7]  = mk(PRE_NONE,  4, 0, 0,  0,  1, 0, 3, 0); // second short frame: unlock
    vecs[8]  = mk(PRE_NONE,  4, 0, 0,  0,  1, 0, 4, 0);
    vecs[9]  = mk(PRE_NONE,  4, 0, 0,  0,  1, 0, 4, 0);
    vecs[10] = mk(PRE_NONE,  4, 0, 0,  0,  1, 0, 4, 0);
    vecs[11] = mk(PRE_NONE,  4, 2, 25, 0,  1, 1, 4, 1); // relocked; short line inside
    vecs[12] = mk(PRE_NONE,  4, 0, 0,  0,  1, 1, 4, 0); // bad frame, still locked
    vecs[13] = mk(PRE_NONE,  3, 0, 0,  0,  1, 1, 4, 0); // good frame cleared bad_cnt
    vecs[14] = mk(PRE_NONE,  4, 0, 0,  0,  1, 1, 3, 0); // single bad again: hold
    vecs[15] = mk(PRE_NONE,  4, 0, 0,  1,  1, 1, 4, 0);
    vecs[16] = mk(PRE_IDLE,  4, 0, 0,  0,  0, 0, 4, 1); // timeout, then reference edge
    vecs[17] = mk(PRE_NONE,  4, 0, 0,  0,  1, 0, 7, 0);
    vecs[18] = mk(PRE_NONE,  4, 0, 0,  0,  1, 0, 4, 0);
    vecs[19] = mk(PRE_NONE,  4, 0, 0,  0,  1, 0, 4, 0);
    vecs[20] = mk(PRE_NONE,  4, 0, 0,  0,  1, 1, 4, 0); // lock regained
    vecs[21] = mk(PRE_RESET, 4, 0, 0,  0,  0, 0, 0, 0); // 1-clk reset mid-frame
    vecs[22] = mk(PRE_NONE,  4, 0, 0,  0,  1, 0, 4, 0);
    vecs[23] = mk(PRE_NONE,  4, 0, 0,  0,  1, 0, 4, 0);

    // Reset with sync held high.
    repeat (3) @(negedge clk);
    check("reset_line_start", ow_line_start, 0);
    check("reset_frame_start", ow_frame_start, 0);
    check("reset_hpos", ow_hpos, 0);
    check("reset_vpos", ow_vpos, 0);
    check("reset_locked", ow_locked, 0);
    check("reset_frame_lines", ow_frame_lines, 0);
    check("reset_line_period", ow_line_period, 0);
    check("reset_sync_err", ow_sync_err, 0);

    // Release while sync is still high: no edge, no strobe.
    reset   = 1'b0;
    strobes = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (ow_line_start || ow_frame_start || ow_sync_err) strobes++;
    end
    check("release_no_strobe", strobes, 0);
    sync = 1'b0;
    tick();
    tick();

    for (int i = 0; i < NVEC; i++) run_frame(i);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
